uart_tx_sched: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_sched.sv | 110 +++++++++++
 tb/tb_uart_tx_sched.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FIFO geometry defaults, scheduler state encoding and
// the idle-timer width helper used by the TX scheduler.
package uart_pkg;

  localparam int UART_FIFO_WIDTH = 8;
  localparam int UART_FIFO_DEPTH = 8;
  localparam int UART_TIMEOUT    = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_LOAD = 2'd2,
    ST_SEND = 2'd3
  } sched_state_t;

  // Timer must be able to hold the value TIMEOUT itself (saturation point).
  function automatic int tmr_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int UART_TMR_W = tmr_w(UART_TIMEOUT);

endpackage

// File: rtl/uart_tx_sched.sv
// Drains the TX FIFO into the serializer in bursts, started by an occupancy
// threshold or by an idle timeout while data is pending.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int FIFO_WIDTH = UART_FIFO_WIDTH,
  parameter int FIFO_DEPTH = UART_FIFO_DEPTH,
  parameter int TIMEOUT    = UART_TIMEOUT,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_en,
  input  logic [$clog2(FIFO_DEPTH):0]  i_threshold,
  input  logic                         i_fifo_empty,
  input  logic [$clog2(FIFO_DEPTH):0]  i_fifo_cnt,
  input  logic [FIFO_WIDTH-1:0]        i_fifo_rdata,
  output logic                         o_fifo_ren,
  output logic                         o_tx_valid,
  output logic [FIFO_WIDTH-1:0]        o_tx_data,
  input  logic                         i_tx_ready,
  output logic                         o_busy,
  output logic [CNT_W-1:0]             o_sent_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = tmr_w(TIMEOUT);

  // Handshake: a byte moves when o_tx_valid && i_tx_ready at a rising edge;
  // o_tx_valid/o_tx_data stay stable until then, and i_tx_ready is ignored
  // while o_tx_valid is low.

  sched_state_t            r_state;
  logic [TW-1:0]           r_timer;
  logic                    r_fifo_ren;
  logic                    r_tx_valid;
  logic [FIFO_WIDTH-1:0]   r_tx_data;
  logic [CNT_W-1:0]        r_sent_cnt;

  logic [CW-1:0]           w_thr_eff;
  logic                    w_pending;
  logic                    w_tmo_hit;
  logic                    w_trigger;
  logic                    w_handshake;

  assign w_thr_eff   = (i_threshold == '0) ? CW'(1) : i_threshold;
  assign w_pending   = i_en && !i_fifo_empty;
  assign w_tmo_hit   = (r_timer == TW'(TIMEOUT));
  assign w_trigger   = w_pending && ((i_fifo_cnt >= w_thr_eff) || w_tmo_hit);
  assign w_handshake = r_tx_valid && i_tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_fifo_ren <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
      r_sent_cnt <= '0;
    end else begin
      r_fifo_ren <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) begin
            r_state    <= ST_READ;
            r_fifo_ren <= 1'b1;
            r_timer    <= '0;
          end else if (!w_pending) begin
            r_timer <= '0;
          end else if (!w_tmo_hit) begin
            r_timer <= r_timer + TW'(1);
          end
        end
        ST_READ: begin
          r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          // FIFO read data is registered, so it is valid in this cycle.
          r_tx_data  <= i_fifo_rdata;
          r_tx_valid <= 1'b1;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          if (w_handshake) begin
            r_tx_valid <= 1'b0;
            r_sent_cnt <= r_sent_cnt + CNT_W'(1);
            // Once a burst is running it continues while data exists,
            // independent of the threshold.
            if (w_pending) begin
              r_state    <= ST_READ;
              r_fifo_ren <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_fifo_ren = r_fifo_ren;
  assign o_tx_valid = r_tx_valid;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_sent_cnt = r_sent_cnt;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: behavioural TX FIFO model, byte
// scoreboard on the TX handshake, and hand-computed timing/count checks.
module tb_uart_tx_sched;

  localparam int FW    = 8;
  localparam int DEPTH = 8;
  localparam int TMO   = 64;
  localparam int CNTW  = 4;

  logic            clk;
  logic            rst_n;
  logic            i_en;
  logic [3:0]      i_threshold;
  logic            i_fifo_empty;
  logic [3:0]      i_fifo_cnt;
  logic [FW-1:0]   i_fifo_rdata;
  logic            o_fifo_ren;
  logic            o_tx_valid;
  logic [FW-1:0]   o_tx_data;
  logic            i_tx_ready;
  logic            o_busy;
  logic [CNTW-1:0] o_sent_cnt;

  int total;
  int bad;

  logic [FW-1:0] fifo_q[$];
  logic [FW-1:0] exp_q[$];

  uart_tx_sched #(
    .FIFO_WIDTH (FW),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO),
    .CNT_W      (CNTW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (i_en),
    .i_threshold  (i_threshold),
    .i_fifo_empty (i_fifo_empty),
    .i_fifo_cnt   (i_fifo_cnt),
    .i_fifo_rdata (i_fifo_rdata),
    .o_fifo_ren   (o_fifo_ren),
    .o_tx_valid   (o_tx_valid),
    .o_tx_data    (o_tx_data),
    .i_tx_ready   (i_tx_ready),
    .o_busy       (o_busy),
    .o_sent_cnt   (o_sent_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- check task ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- FIFO model ----------------
  always @(posedge clk) begin
    if (o_fifo_ren && fifo_q.size() > 0) begin
      i_fifo_rdata <= fifo_q.pop_front();
      i_fifo_cnt   = 4'(fifo_q.size());
      i_fifo_empty = (fifo_q.size() == 0);
    end
  end

  task automatic push_now(input logic [FW-1:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    i_fifo_cnt   = 4'(fifo_q.size());
    i_fifo_empty = 1'b0;
  endtask

  task automatic push(input logic [FW-1:0] b);
    @(negedge clk);
    while (fifo_q.size() >= DEPTH) @(negedge clk);
    push_now(b);
  endtask

  task automatic clear_models();
    fifo_q.delete();
    exp_q.delete();
    i_fifo_cnt   = '0;
    i_fifo_empty = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    #2;
    if (rst_n && o_tx_valid && i_tx_ready) begin
      if (exp_q.size() == 0) chk("sb_extra_byte", 1, 0);
      else                   chk("tx_data", o_tx_data, exp_q.pop_front());
    end
    if (rst_n && o_fifo_ren) chk("ren_while_valid", o_tx_valid, 0);
  end

  // ---------------- bounded waits ----------------
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_tx_valid && n < 300);
    if (!o_tx_valid) chk({tag, "_wait_valid"}, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_busy && n < 300);
    if (o_busy) chk({tag, "_wait_idle"}, 1, 0);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((o_busy || fifo_q.size() != 0) && n < 500);
    if (o_busy || fifo_q.size() != 0) chk({tag, "_wait_drain"}, 1, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    i_en         = 1'b0;
    i_threshold  = 4'd4;
    i_tx_ready   = 1'b1;
    i_fifo_rdata = '0;
    clear_models();
    repeat (3) @(negedge clk);
    chk("rst_busy",  o_busy, 0);
    chk("rst_valid", o_tx_valid, 0);
    chk("rst_ren",   o_fifo_ren, 0);
    chk("rst_data",  o_tx_data, 0);
    chk("rst_cnt",   o_sent_cnt, 0);
    rst_n = 1'b1;

    // Threshold trigger
    i_en = 1'b1;
    i_threshold = 4'd4;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    @(negedge clk);
    chk("thr_no_early", {o_fifo_ren, o_busy}, 0);
    push(8'h44);
    @(negedge clk);
    chk("thr_ren", o_fifo_ren, 1);
    wait_drain("thr");
    chk("thr_cnt", o_sent_cnt, 4);
    chk("thr_sb_empty", exp_q.size(), 0);

    // Timeout trigger: ren appears TIMEOUT+1 edges after the write
    i_threshold = 4'd8;
    push(8'hA5);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_fifo_ren && n < 200);
    chk("tmo_delay", n, TMO + 1);
    wait_drain("tmo");
    chk("tmo_cnt", o_sent_cnt, 5);

    // Backpressure
    i_threshold = 4'd1;
    i_tx_ready = 1'b0;
    push(8'h5A);
    wait_valid("bp");
    push_now(8'h5B);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", o_tx_valid, 1);
      chk("bp_data",  o_tx_data, 8'h5A);
      chk("bp_ren",   o_fifo_ren, 0);
    end
    i_tx_ready = 1'b1;
    wait_drain("bp");
    chk("bp_cnt", o_sent_cnt, 7);

    // Disable mid-burst
    i_en = 1'b0;
    i_threshold = 4'd5;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    push(8'h05);
    i_tx_ready = 1'b0;
    i_en = 1'b1;
    wait_valid("dis1");
    i_tx_ready = 1'b1;
    @(negedge clk);
    i_tx_ready = 1'b0;
    wait_valid("dis2");
    i_en = 1'b0;
    i_tx_ready = 1'b1;
    wait_idle("dis");
    chk("dis_cnt",   o_sent_cnt, 9);
    chk("dis_fifo",  fifo_q.size(), 3);
    chk("dis_busy",  o_busy, 0);
    chk("dis_timer", dut.r_timer, 0);
    repeat (10) @(negedge clk);
    chk("dis_fifo_hold",  fifo_q.size(), 3);
    chk("dis_timer_hold", dut.r_timer, 0);
    i_threshold = 4'd1;
    i_en = 1'b1;
    wait_drain("dis_rest");
    chk("dis_rest_cnt", o_sent_cnt, 12);

    // Threshold 0 behaves as 1
    i_threshold = 4'd0;
    push(8'h77);
    @(negedge clk);
    chk("thr0_ren", o_fifo_ren, 1);
    wait_drain("thr0");
    chk("thr0_cnt", o_sent_cnt, 13);

    // Threshold above depth: only the timeout starts the burst
    i_threshold = 4'(DEPTH + 1);
    push(8'h80);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n < DEPTH && !o_fifo_ren) push_now(8'h80 + 8'(n));
    end while (!o_fifo_ren && n < 200);
    chk("thr_hi_delay", n, TMO + 1);
    wait_drain("thr_hi");
    chk("thr_hi_cnt", o_sent_cnt, 5);

    // Reset while in SEND
    i_threshold = 4'd1;
    i_tx_ready = 1'b0;
    push(8'hC3);
    wait_valid("rst");
    chk("rst_pre_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", o_tx_valid, 0);
    chk("rst_mid_busy",  o_busy, 0);
    chk("rst_mid_cnt",   o_sent_cnt, 0);
    clear_models();
    i_tx_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Counter wrap: 17 bytes with a 4-bit counter
    for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
    wait_drain("wrap");
    chk("wrap_cnt", o_sent_cnt, 1);
    chk("wrap_sb_empty", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
